// File: rtl/hit_pkg.sv
// -----------------------------------------------------------------------------
// hit_pkg
// Shared types and constants for the target hit detector:
//   - fsm_e   : round state (IDLE / ACTIVE / DONE)
//   - phase_e : guard phase (AWAY / WATCH)
//   - default hit-box half size and guard phase lengths
//   - in_span : overflow-safe 1-D window test used by hit_box
// -----------------------------------------------------------------------------
package hit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fsm_e;

    typedef enum logic {
        AWAY  = 1'b0,
        WATCH = 1'b1
    } phase_e;

    localparam logic [9:0] DEF_HALF         = 10'd16;
    localparam logic [7:0] DEF_AWAY_FRAMES  = 8'd90;
    localparam logic [7:0] DEF_WATCH_FRAMES = 8'd45;

    // True when v lies in [c - h, c + h). The lower bound is tested as
    // v + h >= c in 11 bits so a centre closer to zero than h cannot wrap.
    function automatic logic in_span(
        input logic [9:0] v,
        input logic [9:0] c,
        input logic [9:0] h
    );
        logic [10:0] v_plus_h;
        logic [10:0] c_plus_h;
        v_plus_h = {1'b0, v} + {1'b0, h};
        c_plus_h = {1'b0, c} + {1'b0, h};
        return (v_plus_h >= {1'b0, c}) && ({1'b0, v} < c_plus_h);
    endfunction

endpackage

// File: rtl/hit_box.sv
// -----------------------------------------------------------------------------
// hit_box
// Combinational test of whether the cursor lies inside one square target.
// The box spans [X-HALF, X+HALF) in x and [Y-HALF, Y+HALF) in y.
// Ports:
//   cursor_x, cursor_y : in  10  cursor position
//   hit                : out 1   cursor inside the box
// -----------------------------------------------------------------------------
module hit_box
    import hit_pkg::*;
#(
    parameter logic [9:0] X    = 10'd0,
    parameter logic [9:0] Y    = 10'd0,
    parameter logic [9:0] HALF = DEF_HALF
) (
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    output logic       hit
);

    assign hit = in_span(cursor_x, X, HALF) && in_span(cursor_y, Y, HALF);

endmodule

// File: rtl/target_hit_detector.sv
// -----------------------------------------------------------------------------
// target_hit_detector
// Turns mouse clicks and the guard's watch cycle into per-target scoring
// flags and a sticky "caught" flag for the downstream game-state controller.
//
// Optional feature macro: WATCH_GRACE_EN
//   When defined, clicks during the first GRACE_FRAMES frame ticks of each
//   WATCH phase are judged as if the guard were looking away.
//
// Ports:
//   Clk             : in  1   system clock
//   Reset           : in  1   asynchronous active-high reset
//   frame_tick      : in  1   one-cycle pulse per video frame
//   game_start      : in  1   level; forces IDLE and clears all flags
//   ready           : in  1   one-cycle pulse; starts the round
//   leftButton      : in  1   raw mouse left button level
//   cursorX/cursorY : in  10  cursor position
//   scoring_A/B/C   : out 1   target hit, held until the next round
//   gameover_caught : out 1   sticky catch flag
//   guard_watching  : out 1   guard currently watching
//   phase_count     : out 8   frames remaining in the current guard phase
// -----------------------------------------------------------------------------
module target_hit_detector
    import hit_pkg::*;
#(
    parameter logic [9:0] HALF         = DEF_HALF,
    parameter logic [9:0] A_X          = 10'd120,
    parameter logic [9:0] A_Y          = 10'd240,
    parameter logic [9:0] B_X          = 10'd320,
    parameter logic [9:0] B_Y          = 10'd120,
    parameter logic [9:0] C_X          = 10'd520,
    parameter logic [9:0] C_Y          = 10'd240,
    parameter logic [7:0] AWAY_FRAMES  = DEF_AWAY_FRAMES,
    parameter logic [7:0] WATCH_FRAMES = DEF_WATCH_FRAMES
`ifdef WATCH_GRACE_EN
    ,
    parameter logic [7:0] GRACE_FRAMES = 8'd6
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       ready,
    input  logic       leftButton,
    input  logic [9:0] cursorX,
    input  logic [9:0] cursorY,
    output logic       scoring_A,
    output logic       scoring_B,
    output logic       scoring_C,
    output logic       gameover_caught,
    output logic       guard_watching,
    output logic [7:0] phase_count
);

    fsm_e       state_q,   state_d;
    phase_e     phase_q,   phase_d;
    logic [7:0] count_q,   count_d;
    logic       btn_prev_q, btn_prev_d;
    logic       score_a_q, score_a_d;
    logic       score_b_q, score_b_d;
    logic       score_c_q, score_c_d;
    logic       caught_q,  caught_d;

    logic       hit_a_s;
    logic       hit_b_s;
    logic       hit_c_s;
    logic       click_s;
    logic       judge_watch_s;

    hit_box #(.X(A_X), .Y(A_Y), .HALF(HALF)) u_box_a (
        .cursor_x (cursorX),
        .cursor_y (cursorY),
        .hit      (hit_a_s)
    );

    hit_box #(.X(B_X), .Y(B_Y), .HALF(HALF)) u_box_b (
        .cursor_x (cursorX),
        .cursor_y (cursorY),
        .hit      (hit_b_s)
    );

    hit_box #(.X(C_X), .Y(C_Y), .HALF(HALF)) u_box_c (
        .cursor_x (cursorX),
        .cursor_y (cursorY),
        .hit      (hit_c_s)
    );

    // One event per press: a held button only counts on its rising edge.
    assign click_s = leftButton & ~btn_prev_q;

    // Clicks are judged against the current (pre-flip) phase register.
`ifdef WATCH_GRACE_EN
    assign judge_watch_s = (phase_q == WATCH) &&
                           !(count_q > (WATCH_FRAMES - GRACE_FRAMES));
`else
    assign judge_watch_s = (phase_q == WATCH);
`endif

    // Next-state logic for the round FSM, guard timer and hit flags.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        count_d    = count_q;
        score_a_d  = score_a_q;
        score_b_d  = score_b_q;
        score_c_d  = score_c_q;
        caught_d   = caught_q;
        btn_prev_d = leftButton;

        if (game_start) begin
            state_d   = IDLE;
            phase_d   = AWAY;
            count_d   = AWAY_FRAMES;
            score_a_d = 1'b0;
            score_b_d = 1'b0;
            score_c_d = 1'b0;
            caught_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    phase_d   = AWAY;
                    count_d   = AWAY_FRAMES;
                    score_a_d = 1'b0;
                    score_b_d = 1'b0;
                    score_c_d = 1'b0;
                    caught_d  = 1'b0;
                    if (ready) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end

                ACTIVE: begin
                    // Decided on registered flags, so DONE follows one cycle
                    // after the deciding click.
                    if (caught_q || (score_a_q && score_b_q && score_c_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACTIVE;
                    end

                    if (frame_tick) begin
                        if (count_q == 8'd1) begin
                            if (phase_q == AWAY) begin
                                phase_d = WATCH;
                                count_d = WATCH_FRAMES;
                            end else begin
                                phase_d = AWAY;
                                count_d = AWAY_FRAMES;
                            end
                        end else begin
                            count_d = count_q - 8'd1;
                        end
                    end else begin
                        count_d = count_q;
                    end

                    // Priority A > B > C; re-hitting a scored target while
                    // the guard is away just keeps its flag set.
                    if (click_s) begin
                        if (hit_a_s) begin
                            if (judge_watch_s) begin
                                caught_d = 1'b1;
                            end else begin
                                score_a_d = 1'b1;
                            end
                        end else if (hit_b_s) begin
                            if (judge_watch_s) begin
                                caught_d = 1'b1;
                            end else begin
                                score_b_d = 1'b1;
                            end
                        end else if (hit_c_s) begin
                            if (judge_watch_s) begin
                                caught_d = 1'b1;
                            end else begin
                                score_c_d = 1'b1;
                            end
                        end else begin
                            caught_d = caught_q;
                        end
                    end else begin
                        caught_d = caught_q;
                    end
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d   = IDLE;
                    phase_d   = AWAY;
                    count_d   = AWAY_FRAMES;
                    score_a_d = 1'b0;
                    score_b_d = 1'b0;
                    score_c_d = 1'b0;
                    caught_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            phase_q    <= AWAY;
            count_q    <= AWAY_FRAMES;
            btn_prev_q <= 1'b0;
            score_a_q  <= 1'b0;
            score_b_q  <= 1'b0;
            score_c_q  <= 1'b0;
            caught_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            btn_prev_q <= btn_prev_d;
            score_a_q  <= score_a_d;
            score_b_q  <= score_b_d;
            score_c_q  <= score_c_d;
            caught_q   <= caught_d;
        end
    end

    assign scoring_A       = score_a_q;
    assign scoring_B       = score_b_q;
    assign scoring_C       = score_c_q;
    assign gameover_caught = caught_q;
    assign guard_watching  = (phase_q == WATCH);
    assign phase_count     = count_q;

endmodule

// File: tb/tb_target_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_target_hit_detector
// Scoreboard bench: each click pushes its expected output snapshot, and the
// snapshot is popped and compared one clock after the click is driven.
// A second instance with target A at (8,8) exercises the low-edge box test.
// -----------------------------------------------------------------------------
module tb_target_hit_detector;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       game_start;
    logic       ready;
    logic       leftButton;
    logic [9:0] cursorX;
    logic [9:0] cursorY;

    logic       scoring_A, scoring_B, scoring_C;
    logic       gameover_caught, guard_watching;
    logic [7:0] phase_count;

    logic       lo_sa, lo_sb, lo_sc, lo_caught, lo_watch;
    logic [7:0] lo_pc;

    typedef struct {
        string      tag;
        logic [2:0] score;
        logic       caught;
        logic       watch;
        logic [7:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rises;
    logic prev_a;

    target_hit_detector dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_tick      (frame_tick),
        .game_start      (game_start),
        .ready           (ready),
        .leftButton      (leftButton),
        .cursorX         (cursorX),
        .cursorY         (cursorY),
        .scoring_A       (scoring_A),
        .scoring_B       (scoring_B),
        .scoring_C       (scoring_C),
        .gameover_caught (gameover_caught),
        .guard_watching  (guard_watching),
        .phase_count     (phase_count)
    );

    target_hit_detector #(.A_X(10'd8), .A_Y(10'd8)) dut_lo (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_tick      (frame_tick),
        .game_start      (game_start),
        .ready           (ready),
        .leftButton      (leftButton),
        .cursorX         (cursorX),
        .cursorY         (cursorY),
        .scoring_A       (lo_sa),
        .scoring_B       (lo_sb),
        .scoring_C       (lo_sc),
        .gameover_caught (lo_caught),
        .guard_watching  (lo_watch),
        .phase_count     (lo_pc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] s, input logic c,
                        input logic w, input logic [7:0] pc);
        exp_t e;
        e.tag = tag; e.score = s; e.caught = c; e.watch = w; e.pc = pc;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then compare against a pending scoreboard entry.
    task automatic cyc();
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".score"}, {29'd0, scoring_C, scoring_B, scoring_A}, {29'd0, e.score});
            chk({e.tag, ".caught"}, {31'd0, gameover_caught}, {31'd0, e.caught});
            chk({e.tag, ".watch"}, {31'd0, guard_watching}, {31'd0, e.watch});
            chk({e.tag, ".pc"}, {24'd0, phase_count}, {24'd0, e.pc});
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic click(input logic [9:0] x, input logic [9:0] y, input string tag,
                         input logic [2:0] s, input logic c, input logic w,
                         input logic [7:0] pc);
        cursorX    = x;
        cursorY    = y;
        leftButton = 1'b1;
        push(tag, s, c, w, pc);
        cyc();
        leftButton = 1'b0;
        cyc();
    endtask

    task automatic start_round();
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
        ready = 1'b1;
        cyc();
        ready = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; game_start = 1'b0; ready = 1'b0;
        leftButton = 1'b0; cursorX = 10'd0; cursorY = 10'd0;
        #1;
        chk("rst.score", {29'd0, scoring_C, scoring_B, scoring_A}, 32'd0);
        chk("rst.caught", {31'd0, gameover_caught}, 32'd0);
        chk("rst.watch", {31'd0, guard_watching}, 32'd0);
        chk("rst.pc", {24'd0, phase_count}, 32'd90);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;

        // Guard stays frozen while idle.
        tick(3);
        chk("idle_frozen.pc", {24'd0, phase_count}, 32'd90);

        // Round 1: three hits while away, then DONE ignores everything.
        ready = 1'b1; cyc(); ready = 1'b0;
        tick(10);
        chk("t1_tick10.pc", {24'd0, phase_count}, 32'd80);
        click(10'd120, 10'd240, "t1_hitA", 3'b001, 1'b0, 1'b0, 8'd80);
        click(10'd320, 10'd120, "t2_hitB", 3'b011, 1'b0, 1'b0, 8'd80);
        click(10'd520, 10'd240, "t2_hitC", 3'b111, 1'b0, 1'b0, 8'd80);
        click(10'd120, 10'd240, "t2_done_click", 3'b111, 1'b0, 1'b0, 8'd80);
        tick(2);
        chk("t2_done_frozen.pc", {24'd0, phase_count}, 32'd80);

        // Round 2: click coinciding with the flip is judged AWAY, then catch.
        game_start = 1'b1;
        push("t3_clear", 3'b000, 1'b0, 1'b0, 8'd90);
        cyc();
        game_start = 1'b0;
        ready = 1'b1; cyc(); ready = 1'b0;
        tick(89);
        chk("t3_last_away.pc", {24'd0, phase_count}, 32'd1);
        cursorX = 10'd120; cursorY = 10'd240;
        leftButton = 1'b1; frame_tick = 1'b1;
        push("t3_flip_click", 3'b001, 1'b0, 1'b1, 8'd45);
        cyc();
        leftButton = 1'b0; frame_tick = 1'b0;
        cyc();
        click(10'd320, 10'd120, "t3_catch", 3'b001, 1'b1, 1'b1, 8'd45);
        tick(2);
        chk("t3_done_frozen.pc", {24'd0, phase_count}, 32'd45);

        // game_start outranks ready and a click in the same cycle.
        game_start = 1'b1; ready = 1'b1; leftButton = 1'b1;
        cursorX = 10'd120; cursorY = 10'd240;
        push("t3_hold_clear", 3'b000, 1'b0, 1'b0, 8'd90);
        cyc();
        ready = 1'b0;
        push("t3_hold_clear2", 3'b000, 1'b0, 1'b0, 8'd90);
        cyc();
        game_start = 1'b0; leftButton = 1'b0;
        cyc();
        tick(2);
        chk("t3_priority_idle.pc", {24'd0, phase_count}, 32'd90);

        // Held button: exactly one scoring_A rise.
        ready = 1'b1; cyc(); ready = 1'b0;
        leftButton = 1'b1;
        rises = 0;
        prev_a = scoring_A;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (scoring_A && !prev_a) rises++;
            prev_a = scoring_A;
        end
        leftButton = 1'b0;
        cyc();
        chk("t4_rises", rises, 32'd1);
        chk("t4_scoreA", {31'd0, scoring_A}, 32'd1);

        // Box edges and low-coordinate target.
        start_round();
        chk("t5_lo_init", {31'd0, lo_sa}, 32'd0);
        click(10'd1020, 10'd8, "t5_wrap", 3'b000, 1'b0, 1'b0, 8'd90);
        chk("t5_lo_wrap", {31'd0, lo_sa}, 32'd0);
        click(10'd0, 10'd0, "t5_origin", 3'b000, 1'b0, 1'b0, 8'd90);
        chk("t5_lo_origin", {31'd0, lo_sa}, 32'd1);
        click(10'd136, 10'd240, "t5_edge_hi", 3'b000, 1'b0, 1'b0, 8'd90);
        click(10'd135, 10'd240, "t5_inside_hi", 3'b001, 1'b0, 1'b0, 8'd90);
        click(10'd304, 10'd104, "t5_edge_lo", 3'b011, 1'b0, 1'b0, 8'd90);

        // Clicks early in the WATCH phase.
        start_round();
        tick(90);
        chk("t6_watch.pc", {24'd0, phase_count}, 32'd45);
        chk("t6_watch.w", {31'd0, guard_watching}, 32'd1);
        tick(2);
`ifdef WATCH_GRACE_EN
        click(10'd520, 10'd240, "t6_grace", 3'b100, 1'b0, 1'b1, 8'd43);
        tick(4);
        click(10'd120, 10'd240, "t6_after_grace", 3'b100, 1'b1, 1'b1, 8'd39);
`else
        click(10'd520, 10'd240, "t6_no_grace", 3'b000, 1'b1, 1'b1, 8'd43);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/target_hit_detector.md
Name: target_hit_detector

Overview:
- Upstream stage of the game-state controller: turns mouse clicks and the guard's watch cycle into scoring_A/B/C and gameover_caught.
- Owns three fixed on-screen targets (A, B, C) and a guard that alternates between looking away and watching on frame ticks.
- A click on an armed target while the guard looks away scores that target; a click on a target while the guard watches is a catch.

Parameters:
- HALF, 10'd16, half-size of each square target hit box in pixels.
- A_X / A_Y, 10'd120 / 10'd240, centre of target A.
- B_X / B_Y, 10'd320 / 10'd120, centre of target B.
- C_X / C_Y, 10'd520 / 10'd240, centre of target C.
- AWAY_FRAMES, 8'd90, frame ticks the guard looks away.
- WATCH_FRAMES, 8'd45, frame ticks the guard watches.
- GRACE_FRAMES, 8'd6, grace window at the start of watching (optional feature only).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame.
- game_start  in  1  level, high while the controller is in Start.
- ready  in  1  one-cycle pulse; the round begins.
- leftButton  in  1  raw mouse left button level.
- cursorX, cursorY  in  10  cursor position.
- scoring_A, scoring_B, scoring_C  out  1  level; target hit, held until re-arm.
- gameover_caught  out  1  level, sticky catch flag.
- guard_watching  out  1  guard currently watching (for sprite draw).
- phase_count  out  8  frames remaining in the current guard phase.

Behaviour:
- Reset (asynchronous): all outputs 0; phase_count = AWAY_FRAMES; FSM = IDLE; guard phase = AWAY; btn_prev = 0.
- Click event: leftButton & ~btn_prev, with btn_prev registered every Clk. A held button produces exactly one event.
- Hit box: cursorX in [X-HALF, X+HALF) and cursorY in [Y-HALF, Y+HALF). Use 11-bit compare so X-HALF < 0 does not wrap.
- Top FSM:
  - IDLE: outputs cleared, guard frozen at AWAY with phase_count = AWAY_FRAMES. ready -> ACTIVE next cycle.
  - ACTIVE: the guard runs and clicks are evaluated. When gameover_caught is set, or all three scoring flags are high, -> DONE next cycle.
  - DONE: all flags hold, guard frozen, clicks ignored.
  - game_start high in any state -> IDLE, clearing all flags. This takes priority over ready and clicks in the same cycle.
- Guard timer (ACTIVE only):
  - On frame_tick, phase_count decrements.
  - When frame_tick arrives with phase_count == 1, the phase flips and phase_count reloads with the other phase's length (AWAY_FRAMES or WATCH_FRAMES).
  - guard_watching changes on that same edge.
- Click evaluation (ACTIVE, click event):
  - Priority A > B > C; at most one target is affected per click.
  - Click lands on an unhit target and the guard is AWAY: that scoring_x goes high on the next edge.
  - Click lands on any target and the guard is WATCHING: gameover_caught goes high on the next edge. This includes already-hit targets.
  - Click outside all boxes, or on an already-hit target while AWAY: no effect.
- Simultaneous click and phase flip in the same cycle: the click is judged against the pre-flip guard_watching value.
- Latency: click edge to output is 1 Clk.
- Reset mid-round: immediate return to reset values.

Optional Feature:
- Macro: WATCH_GRACE_EN.
- Defined: for the first GRACE_FRAMES frame ticks of each WATCH phase, clicks are judged as AWAY (scoring allowed, no catch). Implemented as phase_count > WATCH_FRAMES - GRACE_FRAMES while watching.
- Undefined: no grace window; the GRACE_FRAMES parameter is unused.

Decomposition:
- Package hit_pkg:
  - FSM enum {IDLE, ACTIVE, DONE}.
  - Guard phase enum {AWAY, WATCH}.
  - Default AWAY_FRAMES, WATCH_FRAMES and HALF constants.
- Sub-module hit_box: combinational box test with parameters X, Y, HALF, instantiated three times.

Test Plan:
- Reset, pulse ready, cursor (120,240), click at tick 10 (guard AWAY) -> scoring_A = 1 one cycle later; others stay 0; gameover_caught = 0.
- Hit A, B and C while AWAY -> all three scoring flags high; FSM reaches DONE; a further click at (120,240) has no effect.
- Run 90 frame ticks -> guard_watching = 1 and phase_count = 45. Click at (320,120) -> gameover_caught = 1, scoring_B = 0. Hold game_start -> all cleared.
- Hold leftButton for 50 cycles over A, with ready pulsed just before -> exactly one scoring_A rise.
- Click at (0,0) with HALF = 16 near a target at x = 8 -> no false hit from underflow. Click at (136,240) -> miss, since the upper bound is exclusive.
- WATCH_GRACE_EN defined: click on C at the 3rd tick of WATCH -> scoring_C = 1, no catch. At the 7th tick -> gameover_caught = 1.
